regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter QDEPTH, default 2, deferred-ALU-write queue depth (power of two, >=2).
REQ-003 SHALL have port clk input 1: single clock, all state on posedge.
REQ-004 SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 SHALL have ports alu_valid input 1, alu_rd input 5, alu_data input XLEN: ALU writeback request.
REQ-006 SHALL have port alu_ready output 1: ALU request accepted this cycle when alu_valid && alu_ready.
REQ-007 SHALL have ports ld_valid input 1, ld_rd input 5, ld_data input XLEN: load-return writeback, never back-pressured.
REQ-008 SHALL have ports iss_ld_valid input 1, iss_ld_rd input 5: load issued, marks rd pending.
REQ-009 SHALL have ports rf_we output 1, rf_waddr output 5, rf_wdata output XLEN: registered single write port to register file.
REQ-010 SHALL have port busy_mask output 32: per-register pending-load scoreboard.

Function
REQ-011 SHALL register rf_we/rf_waddr/rf_wdata: a source selected in cycle N appears on outputs in cycle N+1, held for one cycle.
REQ-012 SHALL give ld_valid absolute priority for the write port every cycle.
REQ-013 SHALL, when no load wins, write the queue head if the queue is non-empty, else write an accepted incoming ALU request directly (bypass).
REQ-014 SHALL enqueue an accepted ALU request when a load wins or the queue is non-empty; ALU writes retire in acceptance order.
REQ-015 SHALL drive alu_ready = 1 when queue count < QDEPTH, or when count == QDEPTH and the head dequeues this cycle (no ld_valid).
REQ-016 SHALL treat enqueue and dequeue in the same cycle as count unchanged, pointers both advance, wrapping modulo QDEPTH.
REQ-017 SHALL suppress rf_we for any write with rd == 0 while still consuming the request/queue entry.
REQ-018 SHALL set busy_mask[iss_ld_rd] on iss_ld_valid and clear busy_mask[ld_rd] on ld_valid; busy_mask[0] is constant 0.
REQ-019 SHALL let set win over clear when iss_ld_rd == ld_rd in the same cycle.
REQ-020 SHALL require upstream not to present an ALU request to an rd with busy_mask set; the block SHALL NOT reorder to resolve it.

Reset
REQ-021 SHALL on reset drive rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, queue empty, pointers 0.
REQ-022 SHALL discard queued entries and drop inputs sampled in the reset cycle; alu_ready=1 the cycle after reset deasserts.

Configuration
REQ-023 SHALL, with RFARB_STATS_EN defined, add output alu_stall_cnt 16 bits counting cycles with alu_valid && !alu_ready, saturating at 16'hFFFF, reset to 0.
REQ-024 SHALL, without RFARB_STATS_EN, omit the port and counter; all other behaviour identical.

Structure
REQ-025 SHALL place the queue entry type (rd, data) and the REG_ADDR_W=5 constant in shared package rv_core_pkg.
REQ-026 SHALL implement the deferred queue as sub-module rfarb_fifo (parameterised depth, count, full/empty).

Verification
REQ-027 Scenario: ALU write rd=5 data=0x1234, idle otherwise -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
REQ-028 Scenario: ld rd=3 data=0xAA and ALU rd=7 data=0xBB same cycle -> cycle+1 writes x3=0xAA, cycle+2 writes x7=0xBB.
REQ-029 Scenario: ld_valid held 4 cycles with ALU requests each cycle -> alu_ready falls after 2 accepts; queued ALU writes retire in order after loads stop.
REQ-030 Scenario: ALU write rd=0 data=0xFF -> rf_we stays 0; alu_ready unaffected.
REQ-031 Scenario: iss_ld rd=9 -> busy_mask[9]=1; same cycle iss_ld rd=9 and ld rd=9 -> busy_mask[9] stays 1; later ld rd=9 alone -> 0.
REQ-032 Scenario: reset asserted with 2 queued entries -> no rf_we after reset, busy_mask=0, alu_stall_cnt=0 when enabled.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core types: register address width and the writeback entry held in
// the deferred ALU write queue.
package rv_core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_MAX   = 64;

    // Data field is sized for the widest supported XLEN; narrower cores zero-extend.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_MAX-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rfarb_fifo.sv
// Circular queue of deferred ALU writebacks; DEPTH must be a power of two so
// the pointers wrap naturally.
module rfarb_fifo
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    wdata,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage needs no reset: an empty queue never exposes stale data.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: loads always win, ALU writes are bypassed or
// deferred in order, plus a pending-load scoreboard. RFARB_STATS_EN adds alu_stall_cnt.
module regfile_wb_arbiter
    import rv_core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    input  logic                  iss_ld_valid,
    input  logic [REG_ADDR_W-1:0] iss_ld_rd,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [31:0]           busy_mask
`ifdef RFARB_STATS_EN
    ,
    output logic [15:0]           alu_stall_cnt
`endif
);

    localparam int QCNT_W = $clog2(QDEPTH + 1);

    wb_entry_t             q_head;
    wb_entry_t             q_wdata;
    logic [QCNT_W-1:0]     q_count;
    logic                  q_full;
    logic                  q_empty;
    logic                  enq;
    logic                  deq;
    logic                  alu_acc;
    logic                  sel_valid;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  unused_bits;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
    logic [31:0]           busy_q, busy_d;

    rfarb_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (enq),
        .pop   (deq),
        .wdata (q_wdata),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign q_wdata     = '{rd: alu_rd, data: XLEN_MAX'(alu_data)};
    assign unused_bits = ^{q_head.data, q_count};

    // A full queue can still accept when its head drains in the same cycle.
    always_comb begin
        deq       = !ld_valid && !q_empty;
        alu_ready = !q_full || deq;
        alu_acc   = alu_valid && alu_ready;
        enq       = alu_acc && (ld_valid || !q_empty);

        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (ld_valid) begin
            sel_valid = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
        end else if (!q_empty) begin
            sel_valid = 1'b1;
            sel_rd    = q_head.rd;
            sel_data  = q_head.data[XLEN-1:0];
        end else if (alu_acc) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end

        rf_we_d    = sel_valid && (sel_rd != '0);
        rf_waddr_d = sel_rd;
        rf_wdata_d = sel_data;

        // Set is applied after clear so a same-register issue wins.
        busy_d = busy_q;
        if (ld_valid) begin
            busy_d[ld_rd] = 1'b0;
        end
        if (iss_ld_valid) begin
            busy_d[iss_ld_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy_mask = busy_q;

`ifdef RFARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (alu_valid && !alu_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign alu_stall_cnt = stall_cnt_q;
`endif

endmodule
